ifetch: RTL and testbench
=========================

# ifetch

Instruction-fetch stage of the Hack CPU, sitting between the program counter and the ROM/execute path. It reads the PC value, issues request/acknowledge fetches to instruction ROM, holds the fetched 16-bit instruction for execute under a valid/ready handshake, and drives the PC's `inc` and `load` controls. Jumps resolved in execute redirect it through `jump`/`jump_addr`, flushing any held or in-flight instruction.

## Interface
- `TIMEOUT`, default 255: ROM acknowledge watchdog limit in cycles, 1..255. Used only with `IFETCH_TIMEOUT_EN`.
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `pc_addr`  in  15  current PC value, the next fetch address
- `pc_inc`  out  1  PC increment pulse, registered
- `pc_load`  out  1  PC load pulse, registered
- `pc_target`  out  15  PC load value, valid while `pc_load` is high
- `rom_req`  out  1  ROM request, registered, level
- `rom_addr`  out  15  ROM address, registered at issue
- `rom_ack`  in  1  ROM data valid, single-cycle
- `rom_data`  in  16  ROM instruction word
- `instr`  out  16  held instruction
- `instr_pc`  out  15  address `instr` was fetched from
- `instr_valid`  out  1  `instr` valid
- `instr_ready`  in  1  execute accepts `instr`
- `jump`  in  1  redirect request, single-cycle
- `jump_addr`  in  15  redirect target
- `fetch_err`  out  1  sticky ROM timeout flag, tied 0 when the feature is absent

## Operation
- States: FETCH, WAIT, FULL, DRAIN, REDIR, plus HALT when the feature is compiled in.
- Issue action: `rom_req`<=1, `rom_addr`<=`pc_addr`, `pc_inc`<=1 for one cycle, next state WAIT.
- FETCH:
  - `jump` → REDIR.
  - Otherwise perform issue.
- WAIT:
  - `jump` without `rom_ack` → DRAIN.
  - `jump` with `rom_ack` → data discarded, `rom_req`<=0, REDIR.
  - `rom_ack` alone → `instr`<=`rom_data`, `instr_pc`<=`rom_addr`, `instr_valid`<=1, `rom_req`<=0, FULL.
- FULL:
  - `jump` → `instr_valid`<=0, REDIR.
  - `instr_ready` → `instr_valid`<=0, perform issue (zero bubble).
  - `jump` with `instr_ready` in the same cycle: `jump` wins and the instruction is discarded.
- DRAIN:
  - Waits for the outstanding ack. `rom_ack` → data discarded, `rom_req`<=0, FETCH.
  - `jump` → new redirect, stays in DRAIN; `jump` with `rom_ack` → REDIR.
- REDIR: lasts one cycle, then FETCH. `jump` → new redirect, stays in REDIR.
- Every `jump` sets `pc_load`<=1 and `pc_target`<=`jump_addr` for exactly one cycle.
- `rom_ack` is ignored outside WAIT and DRAIN.
- `pc_inc` and `pc_load` are never high in the same cycle.

## Timing
- Reset values:
  - state FETCH.
  - `rom_req`, `pc_inc`, `pc_load`, `instr_valid`, `fetch_err` = 0.
  - `rom_addr`, `pc_target`, `instr_pc` = 0; `instr` = 16'h0000.
- Reset mid-operation abandons any in-flight request; a later stray `rom_ack` is ignored.
- The PC updates on the edge after a `pc_inc`/`pc_load` pulse.
  - WAIT lasts at least one cycle, so `pc_addr` is already updated by the next issue.
  - REDIR and DRAIN exist to cover the PC load latency.
- Fetch latency: issue edge → `rom_ack` ≥1 cycle → `instr_valid` high on the edge that samples `rom_ack`.
- Best case throughput: one instruction per 2 cycles when ROM acks in 1 cycle and `instr_ready` is held high.
- Redirect penalty:
  - From FULL: `jump` edge, REDIR, then FETCH issues `jump_addr`; 3 edges to the new request.
  - From WAIT: penalty is extended by the remaining ROM latency.
- Address arithmetic is 15-bit; the PC wraps 32767→0 and ifetch does not special-case it.

## Configuration
- Macro `IFETCH_TIMEOUT_EN`.
- Defined:
  - An 8-bit counter clears on every issue or redirect and counts each cycle in WAIT or DRAIN.
  - When the count reaches `TIMEOUT` without `rom_ack`: `rom_req`<=0, `fetch_err`<=1 (sticky), `instr_valid`<=0, enter HALT.
  - HALT ignores `jump` and `rom_ack` and is left only by `rst`.
- Undefined: no counter and no HALT state; waits indefinitely; `fetch_err` is constant 0.

## Test plan
- Reset, then ROM acks in 1 cycle with `instr_ready`=1 and `pc_addr` driven by pc.v from 0:
  - `rom_addr` sequence is 0,1,2,3.
  - `instr_pc` matches and `instr` equals the ROM contents.
  - One `pc_inc` per fetch; `pc_load` never asserted.
- `instr_ready`=0 for 5 cycles in FULL:
  - `instr` and `instr_valid` stay stable.
  - No new `rom_req`; `pc_inc` stays low.
- `jump` with `jump_addr`=15'h0100 while in FULL:
  - `instr_valid` drops on the next edge.
  - `pc_load` is a one-cycle pulse with `pc_target`=0x0100.
  - The next `rom_addr` is 0x0100.
- `jump` (addr 0x0040) in WAIT with ack delayed 4 cycles:
  - The late data never appears on `instr`.
  - The next `rom_addr` is 0x0040.
- `jump` and `instr_ready` in the same cycle in FULL: the instruction is not counted as accepted; the next fetch is from `jump_addr`.
- `IFETCH_TIMEOUT_EN` with `TIMEOUT`=8 and ROM never acks:
  - `fetch_err`=1 and `rom_req`=0 after 8 WAIT cycles.
  - A subsequent `jump` has no effect; `rst` clears `fetch_err`.

Source files
------------

// File: rtl/ifetch.sv
// Hack CPU instruction-fetch stage: ROM req/ack fetch, valid/ready hand-off, PC inc/load control.
// Optional ROM acknowledge watchdog with sticky error and HALT state: define IFETCH_TIMEOUT_EN.
module ifetch #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [14:0] pc_addr,
   output logic        pc_inc,
   output logic        pc_load,
   output logic [14:0] pc_target,
   output logic        rom_req,
   output logic [14:0] rom_addr,
   input  logic        rom_ack,
   input  logic [15:0] rom_data,
   output logic [15:0] instr,
   output logic [14:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        jump,
   input  logic [14:0] jump_addr,
   output logic        fetch_err
);

   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
      $error("ifetch: TIMEOUT must be 1..255");
   end

`ifdef IFETCH_TIMEOUT_EN
   typedef enum logic [2:0] {FETCH, WAIT, FULL, DRAIN, REDIR, HALT} state_t;
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
   logic [7:0] cnt;
`else
   typedef enum logic [2:0] {FETCH, WAIT, FULL, DRAIN, REDIR} state_t;
   assign fetch_err = 1'b0;
`endif

   state_t state;
   logic   jmp_ok;

`ifdef IFETCH_TIMEOUT_EN
   assign jmp_ok = jump && (state != HALT);
`else
   assign jmp_ok = jump;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= FETCH;
         pc_inc      <= 1'b0;
         pc_load     <= 1'b0;
         pc_target   <= '0;
         rom_req     <= 1'b0;
         rom_addr    <= '0;
         instr       <= 16'h0000;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
`ifdef IFETCH_TIMEOUT_EN
         cnt         <= '0;
         fetch_err   <= 1'b0;
`endif
      end else begin
         pc_inc  <= 1'b0;
         pc_load <= 1'b0;
         if (jmp_ok) begin
            pc_load   <= 1'b1;
            pc_target <= jump_addr;
`ifdef IFETCH_TIMEOUT_EN
            cnt       <= '0;
`endif
         end

         case (state)
            FETCH: begin
               if (jump) state <= REDIR;
               else begin
                  rom_req  <= 1'b1;
                  rom_addr <= pc_addr;
                  pc_inc   <= 1'b1;
                  state    <= WAIT;
`ifdef IFETCH_TIMEOUT_EN
                  cnt      <= '0;
`endif
               end
            end
            WAIT: begin
               if (jump) begin
                  if (rom_ack) begin
                     rom_req <= 1'b0;
                     state   <= REDIR;
                  end else state <= DRAIN;
               end else if (rom_ack) begin
                  instr       <= rom_data;
                  instr_pc    <= rom_addr;
                  instr_valid <= 1'b1;
                  rom_req     <= 1'b0;
                  state       <= FULL;
               end
`ifdef IFETCH_TIMEOUT_EN
               else if (cnt == TO_LAST) begin
                  rom_req     <= 1'b0;
                  fetch_err   <= 1'b1;
                  instr_valid <= 1'b0;
                  state       <= HALT;
               end else cnt <= cnt + 8'd1;
`endif
            end
            FULL: begin
               // jump beats a same-cycle accept: the held instruction is dropped
               if (jump) begin
                  instr_valid <= 1'b0;
                  state       <= REDIR;
               end else if (instr_ready) begin
                  instr_valid <= 1'b0;
                  rom_req     <= 1'b1;
                  rom_addr    <= pc_addr;
                  pc_inc      <= 1'b1;
                  state       <= WAIT;
`ifdef IFETCH_TIMEOUT_EN
                  cnt         <= '0;
`endif
               end
            end
            DRAIN: begin
               if (rom_ack) begin
                  rom_req <= 1'b0;
                  state   <= jump ? REDIR : FETCH;
               end
`ifdef IFETCH_TIMEOUT_EN
               else if (!jump) begin
                  if (cnt == TO_LAST) begin
                     rom_req     <= 1'b0;
                     fetch_err   <= 1'b1;
                     instr_valid <= 1'b0;
                     state       <= HALT;
                  end else cnt <= cnt + 8'd1;
               end
`endif
            end
            REDIR: begin
               if (!jump) state <= FETCH;
            end
`ifdef IFETCH_TIMEOUT_EN
            HALT: state <= HALT;
`endif
            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: PC and ROM models, cycle vector table plus redirect/timeout/reset sequences.
module tb_ifetch;
   logic        clk = 1'b0;
   logic        rst;
   logic [14:0] pc_addr;
   logic        pc_inc, pc_load;
   logic [14:0] pc_target;
   logic        rom_req;
   logic [14:0] rom_addr;
   logic        rom_ack;
   logic [15:0] rom_data;
   logic [15:0] instr;
   logic [14:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        jump;
   logic [14:0] jump_addr;
   logic        fetch_err;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ifetch #(.TIMEOUT(8)) dut (
      .clk(clk), .rst(rst), .pc_addr(pc_addr), .pc_inc(pc_inc), .pc_load(pc_load),
      .pc_target(pc_target), .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack),
      .rom_data(rom_data), .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .jump(jump), .jump_addr(jump_addr), .fetch_err(fetch_err)
   );

   function automatic logic [15:0] rom_fn(input logic [14:0] a);
      return {a[7:0], 8'hA5} ^ {1'b0, a};
   endfunction

   assign rom_data = rom_fn(rom_addr);

   // PC model: load wins over increment, updates on the edge after the pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) pc_addr <= '0;
      else if (pc_load) pc_addr <= pc_target;
      else if (pc_inc) pc_addr <= pc_addr + 15'd1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic a, input logic r, input logic j, input logic [14:0] ja);
      @(negedge clk);
      rom_ack = a; instr_ready = r; jump = j; jump_addr = ja;
      @(posedge clk);
      #1;
      chk("inc_load_excl", {31'd0, pc_inc & pc_load}, 32'd0);
   endtask

   typedef struct {
      logic        ack, rdy, jmp;
      logic [14:0] jaddr;
      logic        req;
      logic [14:0] addr;
      logic        inc, load;
      logic [14:0] tgt;
      logic        vld;
      logic [14:0] ipc;
   } vec_t;

   function automatic vec_t mk(input logic a, input logic r, input logic j, input logic [14:0] ja,
                               input logic q, input logic [14:0] ad, input logic i, input logic l,
                               input logic [14:0] t, input logic v, input logic [14:0] p);
      vec_t x;
      x.ack = a; x.rdy = r; x.jmp = j; x.jaddr = ja; x.req = q; x.addr = ad;
      x.inc = i; x.load = l; x.tgt = t; x.vld = v; x.ipc = p;
      return x;
   endfunction

   vec_t tbl[21];

   task automatic reset_checks(input string tag);
      chk({tag, "_req"},   {31'd0, rom_req}, 0);
      chk({tag, "_inc"},   {31'd0, pc_inc}, 0);
      chk({tag, "_load"},  {31'd0, pc_load}, 0);
      chk({tag, "_vld"},   {31'd0, instr_valid}, 0);
      chk({tag, "_err"},   {31'd0, fetch_err}, 0);
      chk({tag, "_addr"},  {17'd0, rom_addr}, 0);
      chk({tag, "_tgt"},   {17'd0, pc_target}, 0);
      chk({tag, "_ipc"},   {17'd0, instr_pc}, 0);
      chk({tag, "_instr"}, {16'd0, instr}, 0);
   endtask

   initial begin
      // ack, rdy, jmp, jaddr | req, addr, inc, load, tgt, vld, ipc
      tbl[0]  = mk(0,1,0,0,      1,0,1,0,0,0,0);
      tbl[1]  = mk(1,1,0,0,      0,0,0,0,0,1,0);
      tbl[2]  = mk(0,1,0,0,      1,1,1,0,0,0,0);
      tbl[3]  = mk(1,1,0,0,      0,1,0,0,0,1,1);
      tbl[4]  = mk(0,1,0,0,      1,2,1,0,0,0,1);
      tbl[5]  = mk(1,1,0,0,      0,2,0,0,0,1,2);
      tbl[6]  = mk(0,1,0,0,      1,3,1,0,0,0,2);
      tbl[7]  = mk(1,0,0,0,      0,3,0,0,0,1,3);
      tbl[8]  = mk(0,0,0,0,      0,3,0,0,0,1,3);
      tbl[9]  = mk(0,0,0,0,      0,3,0,0,0,1,3);
      tbl[10] = mk(1,0,0,0,      0,3,0,0,0,1,3);
      tbl[11] = mk(0,0,0,0,      0,3,0,0,0,1,3);
      tbl[12] = mk(0,0,0,0,      0,3,0,0,0,1,3);
      tbl[13] = mk(0,0,1,15'h100, 0,3,0,1,15'h100,0,3);
      tbl[14] = mk(0,0,0,0,      0,3,0,0,15'h100,0,3);
      tbl[15] = mk(0,0,0,0,      1,15'h100,1,0,15'h100,0,3);
      tbl[16] = mk(1,0,0,0,      0,15'h100,0,0,15'h100,1,15'h100);
      tbl[17] = mk(0,1,1,15'h200, 0,15'h100,0,1,15'h200,0,15'h100);
      tbl[18] = mk(0,0,0,0,      0,15'h100,0,0,15'h200,0,15'h100);
      tbl[19] = mk(0,0,0,0,      1,15'h200,1,0,15'h200,0,15'h100);
      tbl[20] = mk(1,0,0,0,      0,15'h200,0,0,15'h200,1,15'h200);

      rst = 1'b1; rom_ack = 0; instr_ready = 0; jump = 0; jump_addr = '0;
      repeat (2) @(posedge clk);
      #1;
      reset_checks("rst0");

      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 21; i++) begin
         if (i > 0) @(negedge clk);
         rom_ack = tbl[i].ack; instr_ready = tbl[i].rdy;
         jump = tbl[i].jmp; jump_addr = tbl[i].jaddr;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_req", i),  {31'd0, rom_req}, {31'd0, tbl[i].req});
         chk($sformatf("v%0d_addr", i), {17'd0, rom_addr}, {17'd0, tbl[i].addr});
         chk($sformatf("v%0d_inc", i),  {31'd0, pc_inc}, {31'd0, tbl[i].inc});
         chk($sformatf("v%0d_load", i), {31'd0, pc_load}, {31'd0, tbl[i].load});
         chk($sformatf("v%0d_tgt", i),  {17'd0, pc_target}, {17'd0, tbl[i].tgt});
         chk($sformatf("v%0d_vld", i),  {31'd0, instr_valid}, {31'd0, tbl[i].vld});
         chk($sformatf("v%0d_ipc", i),  {17'd0, instr_pc}, {17'd0, tbl[i].ipc});
         chk($sformatf("v%0d_err", i),  {31'd0, fetch_err}, 0);
         if (tbl[i].vld)
            chk($sformatf("v%0d_instr", i), {16'd0, instr}, {16'd0, rom_fn(tbl[i].ipc)});
      end

      // jump in WAIT, ROM ack arrives 4 cycles after issue
      step(0,1,0,0);
      chk("w_issue_addr", {17'd0, rom_addr}, 32'h201);
      chk("w_issue_req", {31'd0, rom_req}, 1);
      step(0,0,1,15'h40);
      chk("w_jump_load", {31'd0, pc_load}, 1);
      chk("w_jump_tgt", {17'd0, pc_target}, 32'h40);
      for (int k = 0; k < 2; k++) begin
         step(0,0,0,0);
         chk("w_drain_req", {31'd0, rom_req}, 1);
         chk("w_drain_vld", {31'd0, instr_valid}, 0);
      end
      step(1,0,0,0);
      chk("w_late_req", {31'd0, rom_req}, 0);
      chk("w_late_vld", {31'd0, instr_valid}, 0);
      chk("w_late_instr", {16'd0, instr}, {16'd0, rom_fn(15'h200)});
      step(0,0,0,0);
      chk("w_new_addr", {17'd0, rom_addr}, 32'h40);
      chk("w_new_inc", {31'd0, pc_inc}, 1);
      step(1,0,0,0);
      chk("w_new_vld", {31'd0, instr_valid}, 1);
      chk("w_new_ipc", {17'd0, instr_pc}, 32'h40);
      chk("w_new_instr", {16'd0, instr}, {16'd0, rom_fn(15'h40)});

`ifdef IFETCH_TIMEOUT_EN
      step(0,1,0,0);
      chk("t_issue_addr", {17'd0, rom_addr}, 32'h41);
      for (int k = 0; k < 7; k++) begin
         step(0,0,0,0);
         chk("t_wait_err", {31'd0, fetch_err}, 0);
         chk("t_wait_req", {31'd0, rom_req}, 1);
      end
      step(0,0,0,0);
      chk("t_err", {31'd0, fetch_err}, 1);
      chk("t_req", {31'd0, rom_req}, 0);
      chk("t_vld", {31'd0, instr_valid}, 0);
      step(0,0,1,15'h300);
      chk("t_halt_load", {31'd0, pc_load}, 0);
      chk("t_halt_err", {31'd0, fetch_err}, 1);
      step(1,1,0,0);
      chk("t_halt_vld", {31'd0, instr_valid}, 0);
      chk("t_halt_req", {31'd0, rom_req}, 0);
`endif

      // async reset mid-operation, stray ack while leaving reset
      step(0,1,0,0);
      rst = 1'b1;
      #1;
      reset_checks("rst1");
      @(negedge clk);
      rst = 1'b0; rom_ack = 1; instr_ready = 0; jump = 0;
      @(posedge clk);
      #1;
      chk("r_issue_req", {31'd0, rom_req}, 1);
      chk("r_issue_addr", {17'd0, rom_addr}, 0);
      chk("r_stray_vld", {31'd0, instr_valid}, 0);
      step(0,0,0,0);
      chk("r_wait_vld", {31'd0, instr_valid}, 0);
      step(1,0,0,0);
      chk("r_fetch_vld", {31'd0, instr_valid}, 1);
      chk("r_fetch_instr", {16'd0, instr}, {16'd0, rom_fn(15'h0)});

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
